// File: rtl/ysyx_23060061_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter.
// Single transaction in flight, LSU has fixed priority, response timeout.
module ysyx_23060061_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_resp_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_req_wen,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_rdata,
  output logic                lsu_resp_err,
  output logic                slv_req_valid,
  input  logic                slv_req_ready,
  output logic                slv_req_wen,
  output logic [ADDR_W-1:0]   slv_req_addr,
  output logic [DATA_W-1:0]   slv_req_wdata,
  output logic [DATA_W/8-1:0] slv_req_wmask,
  input  logic                slv_resp_valid,
  output logic                slv_resp_ready,
  input  logic [DATA_W-1:0]   slv_resp_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int MW = DATA_W / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    ERR
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MW-1:0]     wmask_q, wmask_d;
  logic              own_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign own_rready = owner_q ? lsu_resp_ready : ifu_resp_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;

    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_rdata = '0;
    ifu_resp_err   = 1'b0;
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_resp_rdata = '0;
    lsu_resp_err   = 1'b0;
    slv_req_valid  = 1'b0;
    slv_req_wen    = wen_q;
    slv_req_addr   = addr_q;
    slv_req_wdata  = wdata_q;
    slv_req_wmask  = wmask_q;
    slv_resp_ready = 1'b0;
    busy           = (state_q != IDLE);
    owner          = owner_q;

    unique case (state_q)
      IDLE: begin
        if (lsu_req_valid) begin
          lsu_req_ready = 1'b1;
          owner_d = 1'b1;
          wen_d   = lsu_req_wen;
          addr_d  = lsu_req_addr;
          wdata_d = lsu_req_wdata;
          wmask_d = lsu_req_wmask;
          state_d = REQ;
        end else if (ifu_req_valid) begin
          ifu_req_ready = 1'b1;
          owner_d = 1'b0;
          wen_d   = 1'b0;
          addr_d  = ifu_req_addr;
          wdata_d = '0;
          wmask_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        slv_req_valid = 1'b1;
        if (slv_req_ready) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        slv_resp_ready = own_rready;
        if (owner_q) begin
          lsu_resp_valid = slv_resp_valid;
          lsu_resp_rdata = wen_q ? '0 : slv_resp_rdata;
        end else begin
          ifu_resp_valid = slv_resp_valid;
          ifu_resp_rdata = wen_q ? '0 : slv_resp_rdata;
        end
        if (slv_resp_valid && own_rready) begin
          state_d = IDLE;
        end else if (!slv_resp_valid) begin
          // saturate rather than wrap so the error exit cannot be skipped
          if (cnt_q != TMAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == TMAX) state_d = ERR;
        end
      end
      ERR: begin
        if (owner_q) begin
          lsu_resp_valid = 1'b1;
          lsu_resp_err   = 1'b1;
        end else begin
          ifu_resp_valid = 1'b1;
          ifu_resp_err   = 1'b1;
        end
        if (own_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      ifu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      ifu_resp_rdata = '0;
      ifu_resp_err   = 1'b0;
      lsu_req_ready  = 1'b0;
      lsu_resp_valid = 1'b0;
      lsu_resp_rdata = '0;
      lsu_resp_err   = 1'b0;
      slv_req_valid  = 1'b0;
      slv_req_wen    = 1'b0;
      slv_req_addr   = '0;
      slv_req_wdata  = '0;
      slv_req_wmask  = '0;
      slv_resp_ready = 1'b0;
      busy           = 1'b0;
      owner          = 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Bench for ysyx_23060061_mem_arbiter: vector table, corner sequences,
// then random traffic against a transaction-level reference.
module tb_ysyx_23060061_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_resp_rdata;
  logic        ifu_resp_err;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_resp_rdata;
  logic        lsu_resp_err;
  logic        slv_req_valid, slv_req_ready, slv_req_wen;
  logic [31:0] slv_req_addr, slv_req_wdata;
  logic [3:0]  slv_req_wmask;
  logic        slv_resp_valid, slv_resp_ready;
  logic [31:0] slv_resp_rdata;
  logic        busy, owner;

  ysyx_23060061_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
    .slv_req_valid(slv_req_valid), .slv_req_ready(slv_req_ready),
    .slv_req_wen(slv_req_wen), .slv_req_addr(slv_req_addr),
    .slv_req_wdata(slv_req_wdata), .slv_req_wmask(slv_req_wmask),
    .slv_resp_valid(slv_resp_valid), .slv_resp_ready(slv_resp_ready),
    .slv_resp_rdata(slv_resp_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        iv;
    logic [31:0] ia;
    logic        lv;
    logic        lw;
    logic [31:0] la;
    logic [31:0] ld;
    logic [3:0]  lm;
    logic        srq;
    logic        srv;
    logic [31:0] srd;
    logic        irr;
    logic        lrr;
    logic        e_irdy;
    logic        e_lrdy;
    logic        e_sv;
    logic        e_swen;
    logic [31:0] e_sa;
    logic [31:0] e_swd;
    logic [3:0]  e_swm;
    logic        e_irv;
    logic [31:0] e_ird;
    logic        e_lrv;
    logic [31:0] e_lrd;
    logic        e_srr;
    logic        e_busy;
    logic        e_own;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [159:0] got,
                     input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic idle_in();
    ifu_req_valid  = 1'b0;
    ifu_req_addr   = '0;
    ifu_resp_ready = 1'b1;
    lsu_req_valid  = 1'b0;
    lsu_req_wen    = 1'b0;
    lsu_req_addr   = '0;
    lsu_req_wdata  = '0;
    lsu_req_wmask  = '0;
    lsu_resp_ready = 1'b1;
    slv_req_ready  = 1'b0;
    slv_resp_valid = 1'b0;
    slv_resp_rdata = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // reference model state for the random phase
  logic [31:0] rmem [16];
  logic [31:0] smem [16];
  logic        r_busy, r_own, r_wen;
  logic [31:0] r_addr, r_wd, r_exp;
  logic [3:0]  r_wm;
  logic        ifu_v, ifu_out, lsu_v, lsu_out, lsu_w;
  logic [31:0] ifu_a, lsu_a, lsu_d;
  logic [3:0]  lsu_m;
  int          s_ph, s_dly, wd;
  logic [31:0] s_data;
  logic        g_l, g_i, hs;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  initial begin
    vt[0]  = '{iv:1'b1, ia:32'h80000000, srq:1'b1, irr:1'b1, lrr:1'b1,
               e_irdy:1'b1, default:'0};
    vt[1]  = '{srq:1'b1, irr:1'b1, lrr:1'b1, e_sv:1'b1,
               e_sa:32'h80000000, e_busy:1'b1, default:'0};
    vt[2]  = '{srv:1'b1, srd:32'h00000413, irr:1'b1, lrr:1'b1,
               e_irv:1'b1, e_ird:32'h00000413, e_srr:1'b1,
               e_busy:1'b1, default:'0};
    vt[3]  = '{irr:1'b1, lrr:1'b1, default:'0};
    vt[4]  = '{iv:1'b1, ia:32'h80000004, lv:1'b1, lw:1'b1,
               la:32'h80001000, ld:32'hDEADBEEF, lm:4'hF, srq:1'b1,
               irr:1'b1, lrr:1'b1, e_lrdy:1'b1, default:'0};
    vt[5]  = '{iv:1'b1, ia:32'h80000004, srq:1'b1, irr:1'b1, lrr:1'b1,
               e_sv:1'b1, e_swen:1'b1, e_sa:32'h80001000,
               e_swd:32'hDEADBEEF, e_swm:4'hF, e_busy:1'b1,
               e_own:1'b1, default:'0};
    vt[6]  = '{iv:1'b1, ia:32'h80000004, srv:1'b1, srd:32'h12345678,
               irr:1'b1, lrr:1'b1, e_lrv:1'b1, e_srr:1'b1,
               e_busy:1'b1, e_own:1'b1, default:'0};
    vt[7]  = '{iv:1'b1, ia:32'h80000004, srq:1'b1, irr:1'b1, lrr:1'b1,
               e_irdy:1'b1, e_own:1'b1, default:'0};
    vt[8]  = '{srq:1'b1, irr:1'b1, lrr:1'b1, e_sv:1'b1,
               e_sa:32'h80000004, e_busy:1'b1, default:'0};
    vt[9]  = '{srv:1'b1, srd:32'h0000AAAA, irr:1'b1, lrr:1'b1,
               e_irv:1'b1, e_ird:32'h0000AAAA, e_srr:1'b1,
               e_busy:1'b1, default:'0};
    vt[10] = '{irr:1'b1, lrr:1'b1, default:'0};

    // reset, with a request present to show outputs stay quiet
    idle_in();
    rst = 1'b1;
    ifu_req_valid = 1'b1;
    tick();
    tick();
    #1;
    chk("reset_outs", 160'({ifu_req_ready, ifu_resp_valid, ifu_resp_err,
        lsu_req_ready, lsu_resp_valid, lsu_resp_err, slv_req_valid,
        slv_resp_ready, busy, owner, slv_req_addr, ifu_resp_rdata}), '0);
    tick();
    idle_in();
    rst = 1'b0;
    #1;
    chk("post_reset", 160'({busy, owner, slv_req_valid}), '0);
    tick();

    for (int i = 0; i < 11; i++) begin
      ifu_req_valid  = vt[i].iv;
      ifu_req_addr   = vt[i].ia;
      lsu_req_valid  = vt[i].lv;
      lsu_req_wen    = vt[i].lw;
      lsu_req_addr   = vt[i].la;
      lsu_req_wdata  = vt[i].ld;
      lsu_req_wmask  = vt[i].lm;
      slv_req_ready  = vt[i].srq;
      slv_resp_valid = vt[i].srv;
      slv_resp_rdata = vt[i].srd;
      ifu_resp_ready = vt[i].irr;
      lsu_resp_ready = vt[i].lrr;
      #1;
      chk($sformatf("vec%0d_ctl", i),
          160'({ifu_req_ready, lsu_req_ready, ifu_resp_valid,
                lsu_resp_valid, slv_req_valid, slv_resp_ready,
                busy, owner}),
          160'({vt[i].e_irdy, vt[i].e_lrdy, vt[i].e_irv, vt[i].e_lrv,
                vt[i].e_sv, vt[i].e_srr, vt[i].e_busy, vt[i].e_own}));
      chk($sformatf("vec%0d_dat", i),
          160'({slv_req_valid ? {slv_req_wen, slv_req_addr,
                slv_req_wdata, slv_req_wmask} : 69'd0,
                ifu_resp_rdata, lsu_resp_rdata}),
          160'({vt[i].e_sv ? {vt[i].e_swen, vt[i].e_sa,
                vt[i].e_swd, vt[i].e_swm} : 69'd0,
                vt[i].e_ird, vt[i].e_lrd}));
      tick();
    end

    // LSU read with request and response wait states plus backpressure
    idle_in();
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h80000010;
    lsu_req_wdata = 32'h55555555;
    #1;
    chk("wait_grant", 160'({lsu_req_ready, ifu_req_ready}), 160'(2'b10));
    tick();
    lsu_req_valid = 1'b0;
    lsu_req_addr  = 32'h0;
    for (int k = 0; k < 4; k++) begin
      slv_req_ready = (k == 3);
      #1;
      chk($sformatf("wait_req%0d", k),
          160'({slv_req_valid, slv_req_wen, slv_req_addr}),
          160'({1'b1, 1'b0, 32'h80000010}));
      tick();
    end
    slv_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("wait_resp%0d", k),
          160'({lsu_resp_valid, ifu_resp_valid, busy}), 160'(3'b001));
      tick();
    end
    slv_resp_valid = 1'b1;
    slv_resp_rdata = 32'hCAFEF00D;
    lsu_resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      lsu_resp_ready = (k == 4);
      #1;
      chk($sformatf("bp%0d", k),
          160'({lsu_resp_valid, slv_resp_ready, ifu_resp_valid,
                busy, lsu_resp_rdata}),
          160'({1'b1, (k == 4), 1'b0, 1'b1, 32'hCAFEF00D}));
      tick();
    end
    idle_in();
    #1;
    chk("bp_done", 160'(busy), '0);
    tick();

    // timeout: slave never answers
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h80000100;
    #1;
    chk("to_grant", 160'(ifu_req_ready), 160'(1));
    tick();
    ifu_req_valid = 1'b0;
    slv_req_ready = 1'b1;
    #1;
    chk("to_req", 160'({slv_req_valid, slv_req_addr}),
        160'({1'b1, 32'h80000100}));
    tick();
    slv_req_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("to_wait%0d", k),
          160'({ifu_resp_valid, ifu_resp_err, busy}), 160'(3'b001));
      tick();
    end
    slv_resp_valid = 1'b1;
    slv_resp_rdata = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      ifu_resp_ready = (k == 2);
      #1;
      chk($sformatf("to_err%0d", k),
          160'({ifu_resp_valid, ifu_resp_err, slv_resp_ready,
                busy, lsu_resp_valid, ifu_resp_rdata}),
          160'({5'b11010, 32'h0}));
      tick();
    end
    idle_in();
    #1;
    chk("to_done", 160'({busy, ifu_resp_err, ifu_resp_valid}), '0);
    tick();

    // reset during RESP abandons the transaction
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h80000200;
    tick();
    ifu_req_valid = 1'b0;
    slv_req_ready = 1'b1;
    tick();
    slv_req_ready = 1'b0;
    #1;
    chk("rst_in_resp", 160'({busy, slv_resp_ready}), 160'(2'b11));
    tick();
    rst = 1'b1;
    slv_resp_valid = 1'b1;
    slv_resp_rdata = 32'h00001234;
    ifu_req_valid = 1'b1;
    tick();
    #1;
    chk("rst_outs", 160'({ifu_req_ready, ifu_resp_valid, ifu_resp_err,
        lsu_req_ready, lsu_resp_valid, lsu_resp_err, slv_req_valid,
        slv_resp_ready, busy, owner, slv_req_addr, ifu_resp_rdata}), '0);
    tick();
    idle_in();
    rst = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h80000300;
    #1;
    chk("rst_regrant", 160'({ifu_req_ready, busy, owner}), 160'(3'b100));
    tick();
    ifu_req_valid = 1'b0;
    slv_req_ready = 1'b1;
    #1;
    chk("rst_req", 160'({slv_req_valid, slv_req_addr}),
        160'({1'b1, 32'h80000300}));
    tick();
    slv_req_ready = 1'b0;
    slv_resp_valid = 1'b1;
    slv_resp_rdata = 32'h00000077;
    #1;
    chk("rst_resp", 160'({ifu_resp_valid, ifu_resp_rdata}),
        160'({1'b1, 32'h77}));
    tick();
    idle_in();
    #1;
    chk("rst_done", 160'(busy), '0);
    tick();

    // random traffic against the transaction-level reference
    for (int i = 0; i < 16; i++) begin
      rmem[i] = 32'hA5A50000 ^ (i * 32'h01010101);
      smem[i] = 32'hA5A50000 ^ (i * 32'h01010101);
    end
    r_busy = 0; r_own = 0; r_wen = 0; r_addr = 0; r_wd = 0; r_wm = 0;
    r_exp = 0;
    ifu_v = 0; ifu_out = 0; lsu_v = 0; lsu_out = 0; lsu_w = 0;
    ifu_a = 0; lsu_a = 0; lsu_d = 0; lsu_m = 0;
    s_ph = 0; s_dly = 0; s_data = 0; wd = 0;
    for (int n = 0; n < 3000; n++) begin
      ifu_req_valid  = ifu_v;
      ifu_req_addr   = ifu_a;
      lsu_req_valid  = lsu_v;
      lsu_req_wen    = lsu_w;
      lsu_req_addr   = lsu_a;
      lsu_req_wdata  = lsu_d;
      lsu_req_wmask  = lsu_m;
      ifu_resp_ready = ($urandom_range(0, 3) != 0);
      lsu_resp_ready = ($urandom_range(0, 3) != 0);
      slv_req_ready  = (s_ph == 0 && s_dly == 0);
      slv_resp_valid = (s_ph == 1 && s_dly == 0);
      slv_resp_rdata = slv_resp_valid ? s_data : $urandom;
      #1;
      g_l = !r_busy && lsu_v;
      g_i = !r_busy && ifu_v && !lsu_v;
      chk("rnd_lsu_rdy", 160'(lsu_req_ready), 160'(g_l));
      chk("rnd_ifu_rdy", 160'(ifu_req_ready), 160'(g_i));
      chk("rnd_stray",
          160'({ifu_resp_valid && !(r_busy && !r_own),
                lsu_resp_valid && !(r_busy && r_own)}), '0);
      if (slv_req_valid && slv_req_ready)
        chk("rnd_slv_req",
            160'({slv_req_wen, slv_req_addr, slv_req_wdata,
                  slv_req_wmask}),
            160'({r_wen, r_addr, r_wd, r_wm}));
      hs = r_busy && (r_own ? (lsu_resp_valid && lsu_resp_ready)
                            : (ifu_resp_valid && ifu_resp_ready));
      if (hs) begin
        if (r_own) begin
          chk("rnd_lsu_resp", 160'({lsu_resp_err, lsu_resp_rdata}),
              160'({1'b0, r_exp}));
          lsu_out = 0;
        end else begin
          chk("rnd_ifu_resp", 160'({ifu_resp_err, ifu_resp_rdata}),
              160'({1'b0, r_exp}));
          ifu_out = 0;
        end
        r_busy = 0;
      end
      if (g_l) begin
        r_own = 1; r_wen = lsu_w; r_addr = lsu_a;
        r_wd = lsu_d; r_wm = lsu_m;
        if (lsu_w) begin
          rmem[lsu_a[5:2]] = merge(rmem[lsu_a[5:2]], lsu_d, lsu_m);
          r_exp = 0;
        end else begin
          r_exp = rmem[lsu_a[5:2]];
        end
        r_busy = 1; lsu_v = 0; lsu_out = 1;
      end else if (g_i) begin
        r_own = 0; r_wen = 0; r_addr = ifu_a; r_wd = 0; r_wm = 0;
        r_exp = rmem[ifu_a[5:2]];
        r_busy = 1; ifu_v = 0; ifu_out = 1;
      end
      if (s_ph == 0) begin
        if (slv_req_valid && slv_req_ready) begin
          if (slv_req_wen) begin
            smem[slv_req_addr[5:2]] = merge(smem[slv_req_addr[5:2]],
                                            slv_req_wdata, slv_req_wmask);
            s_data = $urandom;
          end else begin
            s_data = smem[slv_req_addr[5:2]];
          end
          s_ph = 1;
          s_dly = $urandom_range(0, 3);
        end else if (slv_req_valid && s_dly > 0) begin
          s_dly--;
        end
      end else begin
        if (slv_resp_valid && slv_resp_ready) begin
          s_ph = 0;
          s_dly = $urandom_range(0, 2);
        end else if (s_dly > 0) begin
          s_dly--;
        end
      end
      if (!ifu_v && !ifu_out && $urandom_range(0, 2) == 0) begin
        ifu_v = 1;
        ifu_a = {26'h2000000, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!lsu_v && !lsu_out && $urandom_range(0, 2) == 0) begin
        lsu_v = 1;
        lsu_w = 1'($urandom_range(0, 1));
        lsu_a = {26'h2000000, 4'($urandom_range(0, 15)), 2'b00};
        lsu_d = $urandom;
        lsu_m = 4'($urandom_range(0, 15));
      end
      wd = r_busy ? wd + 1 : 0;
      if (wd == 40) begin
        total++;
        bad++;
        $display("FAIL rnd_watchdog stuck=%0d cycles limit=40", wd);
        wd = 0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
